vga_bounce_box: RTL and testbench

Upstream pixel source for the VGA timing generator: consumes that stage's horizontal/vertical counters and produces the 1-bit-per-channel colour it drives onto the pins during active video. Renders a solid square that bounces off the edges of the 640x480 visible area on a uniform background. Position updates exactly once per frame, at the start of vertical blanking, so a frame never shows a torn box.

---
 rtl/vga_bounce_box.sv | 191 +++++++++++++++++++
 tb/tb_vga_bounce_box.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/vga_bounce_box.sv
// Bouncing-square pixel source for a 640x480 VGA timing generator.
// Optional build macro: BOUNCE_COLOR_EN (box colour steps on each bounce).
module vga_bounce_box #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned BOX_SIZE  = 32,
   parameter int unsigned SPEED     = 2,
   parameter logic [2:0]  BG_COLOR  = 3'b001,
   parameter logic [2:0]  BOX_COLOR = 3'b110
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [9:0] i_hcount,
   input  logic [9:0] i_vcount,
   output logic       o_red_out,
   output logic       o_green_out,
   output logic       o_blue_out,
   output logic [9:0] o_box_x,
   output logic [9:0] o_box_y,
   output logic       o_frame_tick
);

   localparam logic [10:0] HAct   = 11'(H_ACTIVE);
   localparam logic [10:0] VAct   = 11'(V_ACTIVE);
   localparam logic [10:0] BoxSz  = 11'(BOX_SIZE);
   localparam logic [10:0] Speed  = 11'(SPEED);
   localparam logic [9:0]  SpeedN = 10'(SPEED);
   localparam logic [9:0]  XMax   = 10'(H_ACTIVE - BOX_SIZE);
   localparam logic [9:0]  YMax   = 10'(V_ACTIVE - BOX_SIZE);

   logic [9:0] r_box_x;
   logic [9:0] r_box_y;
   logic       r_dir_x;
   logic       r_dir_y;
   logic       r_frame_tick;
   logic [2:0] r_rgb;

   logic       w_trigger;
   logic [10:0] w_x_ext;
   logic [10:0] w_y_ext;
   logic [10:0] w_x_sum;
   logic [10:0] w_y_sum;
   logic [9:0] w_x_diff;
   logic [9:0] w_y_diff;
   logic [9:0] w_x_next;
   logic [9:0] w_y_next;
   logic       w_dir_x_next;
   logic       w_dir_y_next;
   logic       w_x_bounce;
   logic       w_y_bounce;
   logic       w_bounce;
   logic [10:0] w_h;
   logic [10:0] w_v;
   logic       w_active;
   logic       w_in_box;
   logic [2:0] w_box_color;
   logic [2:0] w_rgb_next;

   assign w_trigger = (i_hcount == 10'd0) && ({1'b0, i_vcount} == VAct);

   assign w_x_ext  = {1'b0, r_box_x};
   assign w_y_ext  = {1'b0, r_box_y};
   assign w_x_sum  = w_x_ext + Speed;
   assign w_y_sum  = w_y_ext + Speed;
   assign w_x_diff = r_box_x - SpeedN;
   assign w_y_diff = r_box_y - SpeedN;

   always_comb begin
      w_x_next     = r_box_x;
      w_dir_x_next = r_dir_x;
      w_x_bounce   = 1'b0;
      if (r_dir_x) begin
         if (w_x_sum >= {1'b0, XMax}) begin
            w_x_next     = XMax;
            w_dir_x_next = 1'b0;
            w_x_bounce   = 1'b1;
         end else begin
            w_x_next = w_x_sum[9:0];
         end
      end else begin
         if (w_x_ext <= Speed) begin
            w_x_next     = 10'd0;
            w_dir_x_next = 1'b1;
            w_x_bounce   = 1'b1;
         end else begin
            w_x_next = w_x_diff;
         end
      end
   end

   always_comb begin
      w_y_next     = r_box_y;
      w_dir_y_next = r_dir_y;
      w_y_bounce   = 1'b0;
      if (r_dir_y) begin
         if (w_y_sum >= {1'b0, YMax}) begin
            w_y_next     = YMax;
            w_dir_y_next = 1'b0;
            w_y_bounce   = 1'b1;
         end else begin
            w_y_next = w_y_sum[9:0];
         end
      end else begin
         if (w_y_ext <= Speed) begin
            w_y_next     = 10'd0;
            w_dir_y_next = 1'b1;
            w_y_bounce   = 1'b1;
         end else begin
            w_y_next = w_y_diff;
         end
      end
   end

   // A corner hit is a single event: the OR collapses both axes.
   assign w_bounce = w_x_bounce | w_y_bounce;

`ifdef BOUNCE_COLOR_EN
   logic [2:0] r_box_color;
   logic [2:0] w_color_inc;
   logic [2:0] w_color_next;

   assign w_color_inc = r_box_color + 3'd1;

   // Skip the background colour so the box never vanishes.
   always_comb begin
      w_color_next = w_color_inc;
      if (w_color_inc == BG_COLOR) begin
         w_color_next = r_box_color + 3'd2;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_box_color <= BOX_COLOR;
      end else if (w_trigger && w_bounce) begin
         r_box_color <= w_color_next;
      end
   end

   assign w_box_color = r_box_color;
`else
   assign w_box_color = BOX_COLOR;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_box_x      <= 10'd0;
         r_box_y      <= 10'd0;
         r_dir_x      <= 1'b1;
         r_dir_y      <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_trigger;
         if (w_trigger) begin
            r_box_x <= w_x_next;
            r_box_y <= w_y_next;
            r_dir_x <= w_dir_x_next;
            r_dir_y <= w_dir_y_next;
         end
      end
   end

   assign w_h      = {1'b0, i_hcount};
   assign w_v      = {1'b0, i_vcount};
   assign w_active = (w_h < HAct) && (w_v < VAct);
   assign w_in_box = (w_h >= w_x_ext) && (w_h < w_x_ext + BoxSz) &&
                     (w_v >= w_y_ext) && (w_v < w_y_ext + BoxSz);

   always_comb begin
      w_rgb_next = 3'b000;
      if (w_active) begin
         w_rgb_next = w_in_box ? w_box_color : BG_COLOR;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rgb <= 3'b000;
      end else begin
         r_rgb <= w_rgb_next;
      end
   end

   assign o_red_out    = r_rgb[0];
   assign o_green_out  = r_rgb[1];
   assign o_blue_out   = r_rgb[2];
   assign o_box_x      = r_box_x;
   assign o_box_y      = r_box_y;
   assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Directed bench for vga_bounce_box; honours BOUNCE_COLOR_EN for colour expectations.
module tb_vga_bounce_box;

   logic       r_clk;
   logic       r_rst;
   logic [9:0] r_hcount;
   logic [9:0] r_vcount;
   logic       w_red;
   logic       w_green;
   logic       w_blue;
   logic [9:0] w_box_x;
   logic [9:0] w_box_y;
   logic       w_frame_tick;
   logic [2:0] w_rgb;

   int n_cmp;
   int n_err;

   vga_bounce_box u_dut (
      .i_clk        (r_clk),
      .i_rst        (r_rst),
      .i_hcount     (r_hcount),
      .i_vcount     (r_vcount),
      .o_red_out    (w_red),
      .o_green_out  (w_green),
      .o_blue_out   (w_blue),
      .o_box_x      (w_box_x),
      .o_box_y      (w_box_y),
      .o_frame_tick (w_frame_tick)
   );

   assign w_rgb = {w_blue, w_green, w_red};

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

`ifdef BOUNCE_COLOR_EN
   localparam logic [2:0] ColAfter224 = 3'b111;
   localparam logic [2:0] ColAfter304 = 3'b000;
`else
   localparam logic [2:0] ColAfter224 = 3'b110;
   localparam logic [2:0] ColAfter304 = 3'b110;
`endif

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Apply counters for one clock, then sample 1 time unit after the edge.
   task automatic step(input logic [9:0] h, input logic [9:0] v);
      r_hcount = h;
      r_vcount = v;
      @(posedge r_clk);
      #1;
   endtask

   task automatic run_frame();
      step(10'd0, 10'd480);
      step(10'd1, 10'd480);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      r_rst    = 1'b1;
      r_hcount = 10'd0;
      r_vcount = 10'd0;
      step(10'd0, 10'd0);
      step(10'd0, 10'd0);
      check_eq("reset_rgb", 32'(w_rgb), 32'h0);
      check_eq("reset_x", 32'(w_box_x), 32'd0);
      check_eq("reset_y", 32'(w_box_y), 32'd0);
      check_eq("reset_tick", 32'(w_frame_tick), 32'd0);
      r_rst = 1'b0;

      step(10'd5, 10'd5);
      check_eq("px_box", 32'(w_rgb), 32'b110);
      check_eq("px_box_tick", 32'(w_frame_tick), 32'd0);
      step(10'd100, 10'd5);
      check_eq("px_bg", 32'(w_rgb), 32'b001);
      step(10'd700, 10'd5);
      check_eq("px_hblank", 32'(w_rgb), 32'b000);

      step(10'd31, 10'd0);
      check_eq("edge_x31", 32'(w_rgb), 32'b110);
      step(10'd32, 10'd0);
      check_eq("edge_x32", 32'(w_rgb), 32'b001);
      step(10'd0, 10'd32);
      check_eq("edge_y32", 32'(w_rgb), 32'b001);
      step(10'd0, 10'd31);
      check_eq("edge_y31", 32'(w_rgb), 32'b110);
      step(10'd639, 10'd479);
      check_eq("last_active", 32'(w_rgb), 32'b001);
      step(10'd0, 10'd480);
      check_eq("vblank_rgb", 32'(w_rgb), 32'b000);

      // The previous step was frame 1's trigger.
      check_eq("f1_x", 32'(w_box_x), 32'd2);
      check_eq("f1_y", 32'(w_box_y), 32'd2);
      check_eq("f1_tick", 32'(w_frame_tick), 32'd1);
      step(10'd1, 10'd480);
      check_eq("f1_tick_low", 32'(w_frame_tick), 32'd0);

      for (int i = 2; i <= 224; i++) run_frame();
      check_eq("f224_x", 32'(w_box_x), 32'd448);
      check_eq("f224_y", 32'(w_box_y), 32'd448);
      step(10'd450, 10'd450);
      check_eq("f224_color", 32'(w_rgb), 32'(ColAfter224));
      step(10'd0, 10'd480);
      check_eq("f225_x", 32'(w_box_x), 32'd450);
      check_eq("f225_y", 32'(w_box_y), 32'd446);
      check_eq("f225_tick", 32'(w_frame_tick), 32'd1);
      step(10'd1, 10'd480);

      for (int i = 226; i <= 304; i++) run_frame();
      check_eq("f304_x", 32'(w_box_x), 32'd608);
      check_eq("f304_y", 32'(w_box_y), 32'd288);
      step(10'd639, 10'd300);
      check_eq("f304_color", 32'(w_rgb), 32'(ColAfter304));
      step(10'd607, 10'd300);
      check_eq("f304_left_bg", 32'(w_rgb), 32'b001);
      run_frame();
      check_eq("f305_x", 32'(w_box_x), 32'd606);
      check_eq("f305_y", 32'(w_box_y), 32'd286);

      r_rst = 1'b1;
      step(10'd300, 10'd200);
      check_eq("mid_rst_x", 32'(w_box_x), 32'd0);
      check_eq("mid_rst_y", 32'(w_box_y), 32'd0);
      check_eq("mid_rst_rgb", 32'(w_rgb), 32'h0);
      check_eq("mid_rst_tick", 32'(w_frame_tick), 32'd0);
      r_rst = 1'b0;
      step(10'd5, 10'd5);
      check_eq("redraw_box", 32'(w_rgb), 32'b110);
      step(10'd40, 10'd5);
      check_eq("redraw_bg", 32'(w_rgb), 32'b001);
      step(10'd0, 10'd480);
      check_eq("post_rst_x", 32'(w_box_x), 32'd2);
      check_eq("post_rst_tick", 32'(w_frame_tick), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
